// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller: pixel-clock divider, run/idle control,
// horizontal/vertical counters and registered sync/active/coordinate decode.
module vga_timing_ctrl #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          video_on,
    output logic          pix_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    // state   | meaning
    // IDLE    | counters parked at 0, all outputs at reset values
    // RUN     | scanning; counters advance on each pixel tick
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] H_LAST    = CW'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_BEG = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_ACT_END = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_BEG = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_SYNC + V_BP + V_ACTIVE);

    logic          state, state_nx;
    logic [DW-1:0] div, div_nx;
    logic [CW-1:0] hcount, hcount_nx;
    logic [CW-1:0] vcount, vcount_nx;
    logic          run_nx, tick_nx, ls_nx, fs_nx;
    logic          h_act_nx, v_act_nx, von_nx;
    logic          hs_nx, vs_nx;
    logic [CW-1:0] x_nx, y_nx;

    always_comb begin
        state_nx  = state;
        div_nx    = div;
        hcount_nx = hcount;
        vcount_nx = vcount;
        run_nx    = 1'b0;
        tick_nx   = 1'b0;
        ls_nx     = 1'b0;
        fs_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nx  = ST_RUN;
                    div_nx    = '0;
                    hcount_nx = '0;
                    vcount_nx = '0;
                    run_nx    = 1'b1;
                    ls_nx     = 1'b1;
                    fs_nx     = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // abort is immediate, no completion of the frame
                    state_nx  = ST_IDLE;
                    div_nx    = '0;
                    hcount_nx = '0;
                    vcount_nx = '0;
                end else begin
                    run_nx = 1'b1;
                    if (div == DIV_LAST) begin
                        div_nx  = '0;
                        tick_nx = 1'b1;
                        if (hcount == H_LAST) begin
                            hcount_nx = '0;
                            ls_nx     = 1'b1;
                            if (vcount == V_LAST) begin
                                vcount_nx = '0;
                                fs_nx     = 1'b1;
                            end else begin
                                vcount_nx = vcount + ONE;
                            end
                        end else begin
                            hcount_nx = hcount + ONE;
                        end
                    end else begin
                        div_nx = div + DIV_ONE;
                    end
                end
            end
            default: begin
                state_nx  = ST_IDLE;
                div_nx    = '0;
                hcount_nx = '0;
                vcount_nx = '0;
            end
        endcase

        // decode from next-state counters so outputs line up with them
        hs_nx    = !(run_nx && (hcount_nx < H_SYNC_C));
        vs_nx    = !(run_nx && (vcount_nx < V_SYNC_C));
        h_act_nx = (hcount_nx >= H_ACT_BEG) && (hcount_nx < H_ACT_END);
        v_act_nx = (vcount_nx >= V_ACT_BEG) && (vcount_nx < V_ACT_END);
        von_nx   = run_nx && h_act_nx && v_act_nx;
        x_nx     = von_nx ? (hcount_nx - H_ACT_BEG) : '0;
        y_nx     = von_nx ? (vcount_nx - V_ACT_BEG) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            div         <= div_nx;
            hcount      <= hcount_nx;
            vcount      <= vcount_nx;
            hsync_n     <= hs_nx;
            vsync_n     <= vs_nx;
            video_on    <= von_nx;
            pix_tick    <= tick_nx;
            x           <= x_nx;
            y           <= y_nx;
            line_start  <= ls_nx;
            frame_start <= fs_nx;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: default timing, a short-frame variant
// and a tiny CLK_DIV=1 variant compared cycle by cycle against a model.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // a: default timing
    logic       rst_a_n, en_a;
    logic       hs_a, vs_a, von_a, pt_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    // b: default horizontal, short vertical (2/3/4/1)
    logic       rst_b_n, en_b;
    logic       hs_b, vs_b, von_b, pt_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    // c: CLK_DIV=1, H 2/1/4/1, V 1/1/3/1
    logic       rst_c_n, en_c;
    logic       hs_c, vs_c, von_c, pt_c, ls_c, fs_c;
    logic [3:0] x_c, y_c;

    wire [25:0] out_a = {hs_a, vs_a, von_a, pt_a, ls_a, fs_a, x_a, y_a};
    wire [25:0] out_b = {hs_b, vs_b, von_b, pt_b, ls_b, fs_b, x_b, y_b};
    wire [13:0] out_c = {hs_c, vs_c, von_c, pt_c, ls_c, fs_c, x_c, y_c};
    localparam logic [25:0] RST_AB = {6'b110000, 20'd0};
    localparam logic [13:0] RST_C  = {6'b110000, 8'd0};

    vga_timing_ctrl u_a (
        .clk(clk), .rst_n(rst_a_n), .en(en_a),
        .hsync_n(hs_a), .vsync_n(vs_a), .video_on(von_a), .pix_tick(pt_a),
        .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_ctrl #(
        .CLK_DIV(2), .H_SYNC(96), .H_BP(48), .H_ACTIVE(640), .H_FP(16),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(4), .V_FP(1), .CW(10)
    ) u_b (
        .clk(clk), .rst_n(rst_b_n), .en(en_b),
        .hsync_n(hs_b), .vsync_n(vs_b), .video_on(von_b), .pix_tick(pt_b),
        .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_ctrl #(
        .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .CW(4)
    ) u_c (
        .clk(clk), .rst_n(rst_c_n), .en(en_c),
        .hsync_n(hs_c), .vsync_n(vs_c), .video_on(von_c), .pix_tick(pt_c),
        .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        en_a = 1'b1; en_b = 1'b0; en_c = 1'b0;
        tick(); tick();
        checks++;
        if (out_a !== RST_AB) begin
            failures++;
            $display("FAIL reset_a (en=1): got %h expected %h", out_a, RST_AB);
        end
        checks++;
        if (out_b !== RST_AB) begin
            failures++;
            $display("FAIL reset_b: got %h expected %h", out_b, RST_AB);
        end
        checks++;
        if (out_c !== RST_C) begin
            failures++;
            $display("FAIL reset_c: got %h expected %h", out_c, RST_C);
        end
        en_a = 1'b0;
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_a !== RST_AB) begin
            failures++;
            $display("FAIL idle_hold_a: got %h expected %h", out_a, RST_AB);
        end
    endtask

    task automatic test_start_line;
        int hs_rise = -1, ls_next = -1, vs_rise = -1;
        int pix_cnt = 0, dbl = 0, von_cnt = 0, fs_cnt = 0;
        logic prev_pt = 1'b0;
        en_a = 1'b1;
        tick();
        checks++;
        if ({fs_a, ls_a, hs_a, vs_a} !== 4'b1100) begin
            failures++;
            $display("FAIL start_strobes: got fs,ls,hs,vs=%b expected 1100", {fs_a, ls_a, hs_a, vs_a});
        end
        for (int k = 1; k <= 3300; k++) begin
            tick();
            if (hs_a && hs_rise < 0) hs_rise = k;
            if (ls_a && ls_next < 0) ls_next = k;
            if (vs_a && vs_rise < 0) vs_rise = k;
            if (k <= 1600) begin
                if (pt_a) pix_cnt++;
                if (pt_a && prev_pt) dbl++;
            end
            prev_pt = pt_a;
            if (von_a) von_cnt++;
            if (fs_a) fs_cnt++;
        end
        checks++;
        if (hs_rise != 192) begin
            failures++;
            $display("FAIL hsync_width: got %0d clks expected 192", hs_rise);
        end
        checks++;
        if (ls_next != 1600) begin
            failures++;
            $display("FAIL line_period: got %0d clks expected 1600", ls_next);
        end
        checks++;
        if (vs_rise != 3200) begin
            failures++;
            $display("FAIL vsync_width: got %0d clks expected 3200", vs_rise);
        end
        checks++;
        if (pix_cnt != 800 || dbl != 0) begin
            failures++;
            $display("FAIL pix_tick_rate: got %0d ticks (%0d adjacent) expected 800 (0)", pix_cnt, dbl);
        end
        checks++;
        if (von_cnt != 0 || fs_cnt != 0) begin
            failures++;
            $display("FAIL sync_rows_quiet: got video_on=%0d frame_start=%0d expected 0 0", von_cnt, fs_cnt);
        end
    endtask

    task automatic test_midscan_reset;
        en_a = 1'b0;
        tick();
        en_a = 1'b1;
        tick();
        repeat (1400) tick();
        checks++;
        if ({hs_a, vs_a, von_a} !== 3'b100) begin
            failures++;
            $display("FAIL pre_reset_h700: got hs,vs,von=%b expected 100", {hs_a, vs_a, von_a});
        end
        rst_a_n = 1'b0;
        tick();
        checks++;
        if (out_a !== RST_AB) begin
            failures++;
            $display("FAIL midscan_reset: got %h expected %h", out_a, RST_AB);
        end
        rst_a_n = 1'b1;
        tick();
        checks++;
        if ({fs_a, ls_a, hs_a, vs_a} !== 4'b1100) begin
            failures++;
            $display("FAIL restart_after_reset: got fs,ls,hs,vs=%b expected 1100", {fs_a, ls_a, hs_a, vs_a});
        end
        en_a = 1'b0;
        tick();
    endtask

    task automatic test_abort;
        en_b = 1'b1;
        tick();
        repeat (8600) tick();
        checks++;
        if ({von_b, x_b, y_b} !== {1'b1, 10'd156, 10'd0}) begin
            failures++;
            $display("FAIL pre_abort_pos: got von=%b x=%0d y=%0d expected 1 156 0", von_b, x_b, y_b);
        end
        en_b = 1'b0;
        tick();
        checks++;
        if (out_b !== RST_AB) begin
            failures++;
            $display("FAIL abort_outputs: got %h expected %h", out_b, RST_AB);
        end
        repeat (3) tick();
        checks++;
        if (out_b !== RST_AB) begin
            failures++;
            $display("FAIL abort_idle_hold: got %h expected %h", out_b, RST_AB);
        end
        en_b = 1'b1;
        tick();
        checks++;
        if ({fs_b, ls_b, hs_b, vs_b, von_b} !== 5'b11000) begin
            failures++;
            $display("FAIL abort_restart: got fs,ls,hs,vs,von=%b expected 11000", {fs_b, ls_b, hs_b, vs_b, von_b});
        end
    endtask

    // continues from the restart edge left by test_abort (k = 0)
    task automatic test_frame;
        int rise_k = -1, last_k = -1, fs_k = -1, vs_rise = -1;
        int von_total = 0, row_cnt = 0;
        logic [9:0] rise_x = '1, rise_y = '1, last_x = '1, last_y = '1;
        logic prev_von = 1'b0;
        for (int k = 1; k <= 16000; k++) begin
            tick();
            if (von_b && !prev_von && rise_k < 0) begin
                rise_k = k; rise_x = x_b; rise_y = y_b;
            end
            if (von_b) begin
                last_k = k; last_x = x_b; last_y = y_b;
                von_total++;
                if (k >= 8000 && k < 9600) row_cnt++;
            end
            if (vs_b && vs_rise < 0) vs_rise = k;
            if (fs_b && fs_k < 0) fs_k = k;
            prev_von = von_b;
        end
        checks++;
        if (rise_k != 8288 || rise_x !== 10'd0 || rise_y !== 10'd0) begin
            failures++;
            $display("FAIL first_pixel: got k=%0d x=%0d y=%0d expected 8288 0 0", rise_k, rise_x, rise_y);
        end
        checks++;
        if (last_k != 14367 || last_x !== 10'd639 || last_y !== 10'd3) begin
            failures++;
            $display("FAIL last_pixel: got k=%0d x=%0d y=%0d expected 14367 639 3", last_k, last_x, last_y);
        end
        checks++;
        if (row_cnt != 1280 || von_total != 5120) begin
            failures++;
            $display("FAIL video_on_count: got row=%0d frame=%0d expected 1280 5120", row_cnt, von_total);
        end
        checks++;
        if (vs_rise != 3200) begin
            failures++;
            $display("FAIL frame_vsync_width: got %0d expected 3200", vs_rise);
        end
        checks++;
        if (fs_k != 16000) begin
            failures++;
            $display("FAIL frame_period: got %0d clks expected 16000", fs_k);
        end
        en_b = 1'b0;
        tick();
    endtask

    task automatic test_small_model;
        int mh = 0, mv = 0;
        logic e_von;
        logic [3:0] ex, ey;
        logic [13:0] exp_c;
        en_c = 1'b1;
        tick();
        for (int k = 0; k <= 96; k++) begin
            if (k > 0) begin
                tick();
                if (mh == 7) begin
                    mh = 0;
                    mv = (mv == 5) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
            e_von = (mh >= 3) && (mh < 7) && (mv >= 2) && (mv < 5);
            ex = e_von ? 4'(mh - 3) : 4'd0;
            ey = e_von ? 4'(mv - 2) : 4'd0;
            exp_c = {(mh >= 2), (mv >= 1), e_von, (k > 0), (mh == 0), (mh == 0 && mv == 0), ex, ey};
            checks++;
            if (out_c !== exp_c) begin
                failures++;
                $display("FAIL small_model k=%0d: got %b expected %b", k, out_c, exp_c);
            end
        end
        en_c = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_start_line();
        test_midscan_reset();
        test_abort();
        test_frame();
        test_small_model();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
